// File: rtl/param_counter.sv
// Presettable modulo-N up/down counter with 74x163/190-style cascade enables,
// a wrap pulse and sticky overflow / bad-load flags.
module param_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             SR,
  input  logic             LD,
  input  logic             CTP,
  input  logic             CTT,
  input  logic             UD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Co,
  output logic             WRAP,
  output logic             OVF,
  output logic             ERR
);

  // One extra bit so MODULUS == 2^WIDTH is representable for the load range check.
  localparam logic [WIDTH-1:0] QMAX    = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             at_max, at_min, d_oor;

  assign at_max = (q_q == QMAX);
  assign at_min = (q_q == '0);
  assign d_oor  = ({1'b0, D} >= MOD_EXT);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    err_d  = err_q;
    if (!SR) begin
      q_d   = '0;
      ovf_d = 1'b0;
      err_d = 1'b0;
    end else if (!LD) begin
      if (d_oor) begin
        q_d   = '0;
        err_d = 1'b1;
      end else begin
        q_d = D;
      end
    end else if (CTP && CTT) begin
      if (UD) begin
        q_d    = at_max ? '0 : q_q + WIDTH'(1);
        wrap_d = at_max;
      end else begin
        q_d    = at_min ? QMAX : q_q - WIDTH'(1);
        wrap_d = at_min;
      end
      if (wrap_d) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  // Terminal count is combinational so a cascade ripples within the same cycle.
  assign Co   = CTT & (UD ? at_max : at_min);
  assign Q    = q_q;
  assign WRAP = wrap_q;
  assign OVF  = ovf_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: directed vector table, corner sequences, a two-stage
// decade cascade, an 8-bit binary instance and randomized traffic vs. a model.
module tb_param_counter;

  localparam int M = 10;

  logic CP = 1'b0;
  always #5 CP = ~CP;

  int n_chk = 0;
  int n_fail = 0;

  // main 4-bit / mod-10 instance
  logic cr = 1'b0, sr = 1'b1, ld = 1'b1, ctp = 1'b0, ctt = 1'b0, ud = 1'b1;
  logic [3:0] d = 4'd0;
  logic [3:0] q;
  logic co, wrap, ovf, err;

  param_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
    .CP(CP), .CR(cr), .SR(sr), .LD(ld), .CTP(ctp), .CTT(ctt), .UD(ud),
    .D(d), .Q(q), .Co(co), .WRAP(wrap), .OVF(ovf), .ERR(err));

  // two-stage decade cascade
  logic cr2 = 1'b0, sr2 = 1'b1, ctp2 = 1'b1, ctt2 = 1'b1, ud2 = 1'b1;
  logic [3:0] q_lo, q_hi;
  logic co_lo, co_hi, wrap_lo, wrap_hi, ovf_lo, ovf_hi, err_lo, err_hi;

  param_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .CP(CP), .CR(cr2), .SR(sr2), .LD(1'b1), .CTP(ctp2), .CTT(ctt2), .UD(ud2),
    .D(4'd0), .Q(q_lo), .Co(co_lo), .WRAP(wrap_lo), .OVF(ovf_lo), .ERR(err_lo));
  param_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .CP(CP), .CR(cr2), .SR(sr2), .LD(1'b1), .CTP(ctp2), .CTT(co_lo), .UD(ud2),
    .D(4'd0), .Q(q_hi), .Co(co_hi), .WRAP(wrap_hi), .OVF(ovf_hi), .ERR(err_hi));

  // 8-bit binary instance
  logic cr8 = 1'b0, ld8 = 1'b1, ce8 = 1'b0;
  logic [7:0] d8 = 8'd0;
  logic [7:0] q8;
  logic co8, wrap8, ovf8, err8;

  param_counter #(.WIDTH(8), .MODULUS(256)) u_b8 (
    .CP(CP), .CR(cr8), .SR(1'b1), .LD(ld8), .CTP(ce8), .CTT(ce8), .UD(1'b1),
    .D(d8), .Q(q8), .Co(co8), .WRAP(wrap8), .OVF(ovf8), .ERR(err8));

  // reference model: plain modular arithmetic on integers
  int mq = 0, mwrap = 0, movf = 0, merr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model_co();
    if (!ctt) return 0;
    return ud ? int'(mq == M - 1) : int'(mq == 0);
  endfunction

  task automatic model_reset();
    mq = 0; mwrap = 0; movf = 0; merr = 0;
  endtask

  task automatic model_edge();
    mwrap = 0;
    if (!sr) begin
      mq = 0; movf = 0; merr = 0;
    end else if (!ld) begin
      if (int'(d) >= M) begin mq = 0; merr = 1; end
      else mq = int'(d);
    end else if (ctp && ctt) begin
      if (ud) begin mwrap = int'(mq == M - 1); mq = (mq + 1) % M; end
      else    begin mwrap = int'(mq == 0);     mq = (mq + M - 1) % M; end
      if (mwrap != 0) movf = 1;
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".q"},    int'(q),    mq);
    chk({tag, ".wrap"}, int'(wrap), mwrap);
    chk({tag, ".ovf"},  int'(ovf),  movf);
    chk({tag, ".err"},  int'(err),  merr);
    chk({tag, ".co"},   int'(co),   model_co());
  endtask

  // Drive inputs mid-cycle, check Co combinationally, then one edge.
  task automatic step(input string tag, input logic s, l, p, t, u, input logic [3:0] dv);
    sr = s; ld = l; ctp = p; ctt = t; ud = u; d = dv;
    #1;
    chk({tag, ".co_comb"}, int'(co), model_co());
    model_edge();
    @(posedge CP); #1;
    chk_state(tag);
  endtask

  task automatic reset_main();
    cr = 1'b0;
    #1;
    model_reset();
    chk_state("rst_async");
    @(posedge CP); #1;
    chk("rst_hold.q", int'(q), 0);
    cr = 1'b1;
    #1;
  endtask

  typedef struct {
    int sr, ld, ctp, ctt, ud, d;
    int q, w, o, e, c;
  } vec_t;
  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hw, lw;
    //           sr ld cp ct ud  d    q  w  o  e  c
    tbl[0]  = '{1, 0, 0, 1, 1,  7,   7, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 1, 1,  0,   8, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 1, 1,  0,   9, 0, 0, 0, 1};
    tbl[3]  = '{1, 1, 1, 1, 1,  0,   0, 1, 1, 0, 0};
    tbl[4]  = '{1, 0, 1, 1, 1, 12,   0, 0, 1, 1, 0};
    tbl[5]  = '{1, 1, 1, 1, 0,  0,   9, 1, 1, 1, 0};
    tbl[6]  = '{1, 0, 1, 1, 0,  0,   0, 0, 1, 1, 1};
    tbl[7]  = '{1, 0, 1, 1, 1,  9,   9, 0, 1, 1, 1};
    tbl[8]  = '{0, 0, 1, 1, 1,  5,   0, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 1, 0,  0,   0, 0, 0, 0, 1};
    tbl[10] = '{1, 1, 1, 0, 0,  0,   0, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 1, 1, 0, 15,   0, 0, 0, 1, 1};
    tbl[12] = '{1, 0, 1, 1, 1, 10,   0, 0, 0, 1, 0};
    tbl[13] = '{1, 0, 1, 1, 1,  9,   9, 0, 0, 1, 1};

    #2;
    reset_main();

    for (int i = 0; i < 14; i++) begin
      sr = tbl[i].sr[0]; ld = tbl[i].ld[0]; ctp = tbl[i].ctp[0];
      ctt = tbl[i].ctt[0]; ud = tbl[i].ud[0]; d = tbl[i].d[3:0];
      @(posedge CP); #1;
      chk($sformatf("tbl%0d.q", i),    int'(q),    tbl[i].q);
      chk($sformatf("tbl%0d.wrap", i), int'(wrap), tbl[i].w);
      chk($sformatf("tbl%0d.ovf", i),  int'(ovf),  tbl[i].o);
      chk($sformatf("tbl%0d.err", i),  int'(err),  tbl[i].e);
      chk($sformatf("tbl%0d.co", i),   int'(co),   tbl[i].c);
    end

    // count up 12 edges through the 9 -> 0 wrap
    reset_main();
    for (int i = 0; i < 12; i++) begin
      step("up12", 1, 1, 1, 1, 1, 4'd0);
      chk("up12.q_seq", int'(q), (i + 1) % M);
    end

    // down from 3 through the 0 -> 9 wrap; Co gated by CTT at Q=0
    step("ld3", 1, 0, 0, 1, 0, 4'd3);
    for (int i = 0; i < 5; i++) begin
      step("dn5", 1, 1, 1, 1, 0, 4'd0);
      if (i == 2) begin
        ctt = 1'b0; #1;
        chk("dn5.co_ctt0", int'(co), 0);
        ctt = 1'b1; #1;
        chk("dn5.co_ctt1", int'(co), 1);
      end
    end

    // UD flips Co without a clock edge (Q=0 after load)
    step("ld0", 1, 0, 0, 1, 1, 4'd0);
    ud = 1'b0; #1;
    chk("co_ud_flip", int'(co), 1);

    // each enable alone holds
    for (int i = 0; i < 4; i++) step("ctt0", 1, 1, 1, 0, 1, 4'd0);
    for (int i = 0; i < 4; i++) step("ctp0", 1, 1, 0, 1, 1, 4'd0);

    // async reset pulse between edges while counting
    step("pre_cr", 1, 1, 1, 1, 1, 4'd0);
    step("pre_cr", 1, 1, 1, 1, 1, 4'd0);
    cr = 1'b0; #1;
    chk("cr_pulse.q", int'(q), 0);
    chk("cr_pulse.ovf", int'(ovf), 0);
    chk("cr_pulse.err", int'(err), 0);
    cr = 1'b1; model_reset(); #1;
    step("post_cr", 1, 1, 1, 1, 1, 4'd0);
    chk("post_cr.q1", int'(q), 1);

    // randomized traffic against the model, with occasional async resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        cr = 1'b0; #1;
        model_reset();
        chk_state("rnd_cr");
        cr = 1'b1; #1;
      end
      step("rnd", logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 7) != 0),
           logic'($urandom_range(0, 4) != 0), logic'($urandom_range(0, 4) != 0),
           logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // two-stage cascade: 100 edges up, then one edge down from 00
    cr2 = 1'b1;
    hw = 0; lw = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge CP); #1;
      chk("casc_up", int'(q_hi) * 10 + int'(q_lo), i % 100);
      if (i == 99) chk("casc_co99", int'(co_hi), 1);
      if (wrap_hi) hw++;
      if (wrap_lo) lw++;
    end
    chk("casc_hi_wraps", hw, 1);
    chk("casc_lo_wraps", lw, 10);
    chk("casc_ovf_hi", int'(ovf_hi), 1);
    chk("casc_ovf_lo", int'(ovf_lo), 1);
    chk("casc_err", int'(err_lo | err_hi), 0);
    ud2 = 1'b0; #1;
    chk("casc_co00_dn", int'(co_hi), 1);
    @(posedge CP); #1;
    chk("casc_dn", int'(q_hi) * 10 + int'(q_lo), 99);
    chk("casc_dn_wrap", int'(wrap_hi), 1);

    // 8-bit binary wrap 255 -> 0
    cr8 = 1'b1; ld8 = 1'b0; d8 = 8'd254;
    @(posedge CP); #1;
    chk("b8_load", int'(q8), 254);
    ld8 = 1'b1; ce8 = 1'b1;
    @(posedge CP); #1;
    chk("b8_255", int'(q8), 255);
    chk("b8_co", int'(co8), 1);
    @(posedge CP); #1;
    chk("b8_wrap_q", int'(q8), 0);
    chk("b8_wrap", int'(wrap8), 1);
    chk("b8_ovf", int'(ovf8), 1);
    chk("b8_err", int'(err8), 0);
    @(posedge CP); #1;
    chk("b8_wrap_clr", int'(wrap8), 0);
    chk("b8_q1", int'(q8), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (1..32).
REQ-002 Parameter MODULUS, default 16, count cycle length (2..2^WIDTH); Q spans 0..MODULUS-1.
REQ-003 Port CP  input  1  clock; all state changes except reset occur on its rising edge.
REQ-004 Port CR  input  1  reset, asynchronous, active-low; clears all state immediately.
REQ-005 Port SR  input  1  synchronous clear, active-low.
REQ-006 Port LD  input  1  synchronous parallel load, active-low.
REQ-007 Port CTP  input  1  count enable P (local).
REQ-008 Port CTT  input  1  count enable T (cascade); also gates Co.
REQ-009 Port UD  input  1  direction: 1 = up, 0 = down.
REQ-010 Port D  input  WIDTH  parallel load data.
REQ-011 Port Q  output  WIDTH  registered count value.
REQ-012 Port Co  output  1  ripple carry/borrow for cascading, combinational.
REQ-013 Port WRAP  output  1  registered one-cycle pulse following a wrap-around.
REQ-014 Port OVF  output  1  registered sticky flag: at least one wrap since last clear.
REQ-015 Port ERR  output  1  registered sticky flag: out-of-range load attempted.

Function
REQ-016 Per-edge priority: SR low > LD low > count (CTP=1 and CTT=1) > hold.
REQ-017 SR low: Q=0, OVF=0, ERR=0, WRAP=0 at the next edge, regardless of LD/CTP/CTT/UD.
REQ-018 LD low with SR high and D<MODULUS: Q=D at the next edge; OVF and ERR unchanged; WRAP=0.
REQ-019 LD low with SR high and D>=MODULUS: Q=0 and ERR=1 at the next edge; WRAP=0.
REQ-020 Count up (UD=1): Q=Q+1 if Q<MODULUS-1; Q=0 if Q==MODULUS-1 (wrap).
REQ-021 Count down (UD=0): Q=Q-1 if Q>0; Q=MODULUS-1 if Q==0 (wrap).
REQ-022 No count when CTP=0 or CTT=0; Q, OVF and ERR hold, WRAP=0.
REQ-023 On a wrap edge, WRAP=1 for exactly the following cycle and OVF=1; WRAP=0 on every non-wrap edge.
REQ-024 Co = CTT AND (UD ? Q==MODULUS-1 : Q==0), combinational; Co follows UD and CTT changes without a clock edge.
REQ-025 Cascading: Co of stage n to CTT of stage n+1, common CP, CR, SR and UD; the chain counts MODULUS^N up or down without extra logic.
REQ-026 Direction changes take effect at the next edge with no lost or extra count.
REQ-027 Arithmetic is modulo MODULUS only; Q never leaves 0..MODULUS-1 after reset. MODULUS=2^WIDTH yields plain binary wrap.
REQ-028 Loading D==MODULUS-1 (up) or D==0 (down) asserts Co in the following cycle if CTT=1.

Reset
REQ-029 CR low: Q=0, WRAP=0, OVF=0, ERR=0 immediately, independent of CP.
REQ-030 While CR is low, all other inputs are ignored; Co reflects Q=0 (Co=CTT AND NOT UD).
REQ-031 CR low mid-count or mid-load aborts that operation; the first rising CP edge after CR rises acts normally on the then-current inputs.

Verification (WIDTH=4, MODULUS=10 unless noted)
REQ-032 CR low 1 cycle, then UD=1, CTP=CTT=1 for 12 edges -> Q 1..9,0,1,2; WRAP high only the cycle after Q 9->0; OVF=1 from then on; Co=1 only while Q=9.
REQ-033 Q=3, UD=0, count 5 edges -> Q 2,1,0,9,8; WRAP pulse after 0->9; Co=1 while Q=0 with CTT=1, 0 with CTT=0.
REQ-034 LD=0 with D=7 -> Q=7, ERR=0. LD=0 with D=12 -> Q=0, ERR=1. SR=0 with LD=0 and count enabled on the same edge -> Q=0, OVF=0, ERR=0.
REQ-035 CTP=1, CTT=0 and CTP=0, CTT=1 for 4 edges each -> Q holds, Co=0 while CTT=0, WRAP=0.
REQ-036 Two-stage cascade, up from 00, 100 edges -> tens:units walks 00..99 then 00; upper stage WRAP fires once; then UD=0 from 00 -> 99.
REQ-037 CR pulsed low between edges during counting -> Q=0 and flags clear without a CP edge; counting resumes from 1 at the next edge. Also run WIDTH=8, MODULUS=256: 255->0 wrap.
